// File: rtl/mips_lite_nonpipeline.sv
// Multi-cycle, non-pipelined MIPS-lite reference core: FETCH -> EXEC (-> MEM) per instruction,
// with optional per-category retirement statistics.
module mips_lite_nonpipeline #(
  parameter int FUN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        exit,
  output logic [31:0] pc,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata,
  output logic [31:0] instr_count,
  output logic [31:0] arith_count,
  output logic [31:0] logic_count,
  output logic [31:0] mem_count,
  output logic [31:0] ctrl_count,
  output logic [31:0] branch_taken_count
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALTED} state_t;

  typedef enum logic [5:0] {
    OP_ADD  = 6'd0,  OP_ADDI = 6'd1,  OP_SUB  = 6'd2,  OP_SUBI = 6'd3,
    OP_MUL  = 6'd4,  OP_MULI = 6'd5,  OP_OR   = 6'd6,  OP_ORI  = 6'd7,
    OP_AND  = 6'd8,  OP_ANDI = 6'd9,  OP_XOR  = 6'd10, OP_XORI = 6'd11,
    OP_LDW  = 6'd12, OP_STW  = 6'd13, OP_BZ   = 6'd14, OP_BEQ  = 6'd15,
    OP_JR   = 6'd16, OP_HALT = 6'd17
  } opcode_t;

  localparam bit STATS = (FUN != 0);

  state_t      state, state_next;
  logic [31:0] ir;
  logic [31:0] ea;
  logic [31:0] regs [32];
  logic [31:0] pc_next;

  // Instruction fields; ir stays stable through EXEC and MEM.
  opcode_t     op;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm;
  logic [31:0] rs_val, rt_val;

  assign op     = opcode_t'(ir[31:26]);
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign simm   = {{16{ir[15]}}, ir[15:0]};
  assign rs_val = regs[rs];
  assign rt_val = regs[rt];

  // ALU: odd opcodes 1..11 take the sign-extended immediate as second operand.
  logic        is_alu;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic [4:0]  alu_dest;

  assign is_alu   = (ir[31:26] <= 6'd11);
  assign alu_b    = ir[26] ? simm : rt_val;
  assign alu_dest = ir[26] ? rt : rd;

  always_comb begin
    alu_res = '0;
    unique case (ir[29:27])
      3'd0:    alu_res = rs_val + alu_b;
      3'd1:    alu_res = rs_val - alu_b;
      3'd2:    alu_res = rs_val * alu_b;
      3'd3:    alu_res = rs_val | alu_b;
      3'd4:    alu_res = rs_val & alu_b;
      3'd5:    alu_res = rs_val ^ alu_b;
      default: alu_res = '0;
    endcase
  end

  logic [31:0] pc_plus4;
  logic [31:0] br_target;

  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc + {simm[29:0], 2'b00};

  // Control: next state, pc, writeback and counter increments.
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ea_we;
  logic        inc_instr, inc_arith, inc_logic, inc_mem, inc_ctrl, inc_taken;

  // NOTE: every output of this block gets a default first so no path leaves a
  // value held over from a previous evaluation, which would infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    rf_we      = 1'b0;
    rf_waddr   = alu_dest;
    rf_wdata   = alu_res;
    ea_we      = 1'b0;
    inc_instr  = 1'b0;
    inc_arith  = 1'b0;
    inc_logic  = 1'b0;
    inc_mem    = 1'b0;
    inc_ctrl   = 1'b0;
    inc_taken  = 1'b0;

    unique case (state)
      FETCH: state_next = EXEC;

      EXEC: begin
        state_next = FETCH;
        if (is_alu) begin
          rf_we     = 1'b1;
          pc_next   = pc_plus4;
          inc_instr = 1'b1;
          inc_arith = (ir[31:26] <= 6'd5);
          inc_logic = (ir[31:26] >= 6'd6);
        end else begin
          case (op)
            OP_LDW, OP_STW: begin
              ea_we      = 1'b1;
              state_next = MEM;
            end
            OP_BZ: begin
              inc_instr = 1'b1;
              inc_ctrl  = 1'b1;
              inc_taken = (rs_val == 32'd0);
              pc_next   = (rs_val == 32'd0) ? br_target : pc_plus4;
            end
            OP_BEQ: begin
              inc_instr = 1'b1;
              inc_ctrl  = 1'b1;
              inc_taken = (rs_val == rt_val);
              pc_next   = (rs_val == rt_val) ? br_target : pc_plus4;
            end
            OP_JR: begin
              inc_instr = 1'b1;
              inc_ctrl  = 1'b1;
              inc_taken = 1'b1;
              pc_next   = rs_val;
            end
            OP_HALT: begin
              inc_instr  = 1'b1;
              inc_ctrl   = 1'b1;
              state_next = HALTED;
            end
            default: pc_next = pc_plus4;
          endcase
        end
      end

      MEM: begin
        rf_we      = (op == OP_LDW);
        rf_waddr   = rt;
        rf_wdata   = mem_rdata;
        pc_next    = pc_plus4;
        inc_instr  = 1'b1;
        inc_mem    = 1'b1;
        state_next = FETCH;
      end

      HALTED: state_next = HALTED;

      default: state_next = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
      ea    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == FETCH) ir <= mem_rdata;
      if (ea_we)          ea <= rs_val + simm;
    end
  end

  // NOTE: the register file is reset in full because the architecture defines
  // all 32 registers as zero after reset; this forces flops rather than a RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_count        <= '0;
      arith_count        <= '0;
      logic_count        <= '0;
      mem_count          <= '0;
      ctrl_count         <= '0;
      branch_taken_count <= '0;
    end else if (STATS) begin
      if (inc_instr) instr_count        <= instr_count + 32'd1;
      if (inc_arith) arith_count        <= arith_count + 32'd1;
      if (inc_logic) logic_count        <= logic_count + 32'd1;
      if (inc_mem)   mem_count          <= mem_count + 32'd1;
      if (inc_ctrl)  ctrl_count         <= ctrl_count + 32'd1;
      if (inc_taken) branch_taken_count <= branch_taken_count + 32'd1;
    end
  end

  // The store strobe is qualified by rst_n so a reset landing in MEM cancels the write.
  logic store_cycle;

  assign store_cycle = (state == MEM) && (op == OP_STW);
  assign mem_addr    = (state == MEM) ? ea : pc;
  assign mem_we      = store_cycle && rst_n;
  assign mem_wdata   = store_cycle ? rt_val : 32'd0;
  assign exit        = (state == HALTED);
  assign dbg_rdata   = regs[dbg_raddr];

endmodule

// File: tb/tb_mips_lite_nonpipeline.sv
// Bench for mips_lite_nonpipeline: directed programs plus random programs, compared against an
// instruction-level interpreter; a FUN=1 and a FUN=0 instance run side by side on private memories.
module tb_mips_lite_nonpipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  dbg_raddr;

  logic [31:0] mem_addr1, mem_rdata1, mem_wdata1, pc1, dbg_rdata1;
  logic        mem_we1, exit1;
  logic [31:0] instr1, arith1, logic1, memc1, ctrl1, taken1;

  logic [31:0] mem_addr0, mem_rdata0, mem_wdata0, pc0, dbg_rdata0;
  logic        mem_we0, exit0;
  logic [31:0] instr0, arith0, logic0, memc0, ctrl0, taken0;

  mips_lite_nonpipeline #(.FUN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1),
    .mem_wdata(mem_wdata1), .mem_we(mem_we1), .exit(exit1), .pc(pc1),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata1), .instr_count(instr1),
    .arith_count(arith1), .logic_count(logic1), .mem_count(memc1),
    .ctrl_count(ctrl1), .branch_taken_count(taken1)
  );

  mips_lite_nonpipeline #(.FUN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0),
    .mem_wdata(mem_wdata0), .mem_we(mem_we0), .exit(exit0), .pc(pc0),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata0), .instr_count(instr0),
    .arith_count(arith0), .logic_count(logic0), .mem_count(memc0),
    .ctrl_count(ctrl0), .branch_taken_count(taken0)
  );

  // 4 KB big-endian memories (address wraps at 12 bits); loaded through the same process that stores.
  logic [7:0]  mem1 [0:4095];
  logic [7:0]  mem0 [0:4095];
  logic        ld_we = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  assign mem_rdata1 = {mem1[mem_addr1[11:0]], mem1[mem_addr1[11:0] + 12'd1],
                       mem1[mem_addr1[11:0] + 12'd2], mem1[mem_addr1[11:0] + 12'd3]};
  assign mem_rdata0 = {mem0[mem_addr0[11:0]], mem0[mem_addr0[11:0] + 12'd1],
                       mem0[mem_addr0[11:0] + 12'd2], mem0[mem_addr0[11:0] + 12'd3]};

  always @(posedge clk) begin
    if (ld_we) begin
      mem1[ld_addr] <= ld_data[31:24];  mem1[ld_addr + 12'd1] <= ld_data[23:16];
      mem1[ld_addr + 12'd2] <= ld_data[15:8];  mem1[ld_addr + 12'd3] <= ld_data[7:0];
      mem0[ld_addr] <= ld_data[31:24];  mem0[ld_addr + 12'd1] <= ld_data[23:16];
      mem0[ld_addr + 12'd2] <= ld_data[15:8];  mem0[ld_addr + 12'd3] <= ld_data[7:0];
    end
    if (mem_we1) begin
      mem1[mem_addr1[11:0]] <= mem_wdata1[31:24];  mem1[mem_addr1[11:0] + 12'd1] <= mem_wdata1[23:16];
      mem1[mem_addr1[11:0] + 12'd2] <= mem_wdata1[15:8];  mem1[mem_addr1[11:0] + 12'd3] <= mem_wdata1[7:0];
    end
    if (mem_we0) begin
      mem0[mem_addr0[11:0]] <= mem_wdata0[31:24];  mem0[mem_addr0[11:0] + 12'd1] <= mem_wdata0[23:16];
      mem0[mem_addr0[11:0] + 12'd2] <= mem_wdata0[15:8];  mem0[mem_addr0[11:0] + 12'd3] <= mem_wdata0[7:0];
    end
  end

  int          we_total = 0;
  logic [31:0] we_last_addr = '0;
  always @(posedge clk) begin
    if (mem_we1) begin
      we_total     <= we_total + 1;
      we_last_addr <= mem_addr1;
    end
  end

  function automatic logic [31:0] rd_mem1(logic [31:0] a);
    return {mem1[a[11:0]], mem1[a[11:0] + 12'd1], mem1[a[11:0] + 12'd2], mem1[a[11:0] + 12'd3]};
  endfunction

  function automatic logic [31:0] rd_mem0(logic [31:0] a);
    return {mem0[a[11:0]], mem0[a[11:0] + 12'd1], mem0[a[11:0] + 12'd2], mem0[a[11:0] + 12'd3]};
  endfunction

  // Reference model: architectural state and an instruction-at-a-time interpreter.
  logic [7:0]  m_mem [0:4095];
  logic [31:0] m_reg [32];
  logic [31:0] m_pc, m_instr, m_arith, m_logic, m_memc, m_ctrl, m_taken;
  int          m_cycles;

  function automatic logic [31:0] m_rd(logic [31:0] a);
    return {m_mem[a[11:0]], m_mem[a[11:0] + 12'd1], m_mem[a[11:0] + 12'd2], m_mem[a[11:0] + 12'd3]};
  endfunction

  task automatic m_wr(logic [31:0] a, logic [31:0] d);
    m_mem[a[11:0]] = d[31:24];  m_mem[a[11:0] + 12'd1] = d[23:16];
    m_mem[a[11:0] + 12'd2] = d[15:8];  m_mem[a[11:0] + 12'd3] = d[7:0];
  endtask

  task automatic model_run();
    logic [31:0] ins, a, b, opnd, res, simm, ea;
    int op, rs, rt, rd, steps;
    bit halted;
    for (int r = 0; r < 32; r++) m_reg[r] = '0;
    m_pc = '0; m_instr = '0; m_arith = '0; m_logic = '0; m_memc = '0; m_ctrl = '0; m_taken = '0;
    m_cycles = 0; halted = 0; steps = 0;
    while (!halted && steps < 2000) begin
      ins  = m_rd(m_pc);
      op   = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
      simm = {{16{ins[15]}}, ins[15:0]};
      a    = m_reg[rs]; b = m_reg[rt];
      steps++;
      if (op <= 11) begin
        opnd = (op % 2 == 1) ? simm : b;
        case (op / 2)
          0: res = a + opnd;
          1: res = a - opnd;
          2: res = a * opnd;
          3: res = a | opnd;
          4: res = a & opnd;
          default: res = a ^ opnd;
        endcase
        if (op % 2 == 1) m_reg[rt] = res; else m_reg[rd] = res;
        m_pc += 4; m_cycles += 2; m_instr++;
        if (op < 6) m_arith++; else m_logic++;
      end else begin
        case (op)
          12: begin ea = a + simm; m_reg[rt] = m_rd(ea); m_pc += 4; m_cycles += 3; m_instr++; m_memc++; end
          13: begin ea = a + simm; m_wr(ea, b);         m_pc += 4; m_cycles += 3; m_instr++; m_memc++; end
          14, 15: begin
            if ((op == 14) ? (a == 0) : (a == b)) begin m_pc += simm * 4; m_taken++; end
            else m_pc += 4;
            m_cycles += 2; m_instr++; m_ctrl++;
          end
          16: begin m_pc = a; m_taken++; m_cycles += 2; m_instr++; m_ctrl++; end
          17: begin halted = 1; m_cycles += 2; m_instr++; m_ctrl++; end
          default: begin m_pc += 4; m_cycles += 2; end
        endcase
      end
    end
  endtask

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(int op, int rs, int rt, int rd);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  logic [31:0] prog [$];

  // Called at a negedge; each word takes one clock to land in both DUT memories.
  task automatic load_word(logic [31:0] addr, logic [31:0] data);
    ld_we = 1'b1; ld_addr = addr[11:0]; ld_data = data;
    m_wr(addr, data);
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic load_prog();
    rst_n = 1'b0;
    for (int i = 0; i < prog.size(); i++) load_word(32'(i * 4), prog[i]);
  endtask

  // Releases reset, counts rising edges until exit, and samples pc after edge stop_at.
  task automatic run_dut(int budget, int stop_at, output int cyc, output logic [31:0] pc_at);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0; pc_at = 'x;
    while (exit1 !== 1'b1 && cyc < budget) begin
      @(posedge clk); #1; cyc++;
      if (cyc == stop_at) pc_at = pc1;
    end
    @(negedge clk);
  endtask

  task automatic compare_all(string tag, int cyc);
    check({tag, ".exit1"}, 32'(exit1), 32'd1);
    check({tag, ".exit0"}, 32'(exit0), 32'd1);
    check({tag, ".cycles"}, cyc, m_cycles);
    check({tag, ".pc1"}, pc1, m_pc);
    check({tag, ".pc0"}, pc0, m_pc);
    for (int r = 0; r < 32; r++) begin
      dbg_raddr = 5'(r); #1;
      check($sformatf("%s.r%0d", tag, r), dbg_rdata1, m_reg[r]);
      check($sformatf("%s.r%0d_fun0", tag, r), dbg_rdata0, m_reg[r]);
    end
    check({tag, ".instr"}, instr1, m_instr);
    check({tag, ".arith"}, arith1, m_arith);
    check({tag, ".logic"}, logic1, m_logic);
    check({tag, ".mem"}, memc1, m_memc);
    check({tag, ".ctrl"}, ctrl1, m_ctrl);
    check({tag, ".taken"}, taken1, m_taken);
    check({tag, ".fun0_counters"}, instr0 | arith0 | logic0 | memc0 | ctrl0 | taken0, 32'd0);
    for (int w = 0; w < 64; w++) begin
      check($sformatf("%s.dmem%0d", tag, w), rd_mem1(32'h400 + 32'(w * 4)), m_rd(32'h400 + 32'(w * 4)));
      check($sformatf("%s.dmem%0d_fun0", tag, w), rd_mem0(32'h400 + 32'(w * 4)), m_rd(32'h400 + 32'(w * 4)));
    end
  endtask

  task automatic read_reg(int r, output logic [31:0] v);
    dbg_raddr = 5'(r); #1; v = dbg_rdata1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, we_before, sel;
    logic [31:0] pc_at, v;

    rst_n = 1'b0; dbg_raddr = '0;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) load_word(32'(i * 4), 32'd0);

    // Arithmetic with wrap-around product, exit timing
    prog = {enc_i(1, 0, 1, 5), enc_i(1, 0, 2, -3), enc_r(4, 1, 2, 3), enc_i(17, 0, 0, 0)};
    load_prog(); model_run(); run_dut(200, 0, cyc, pc_at);
    compare_all("arith", cyc);
    read_reg(3, v);
    check("arith.r3_const", v, 32'hFFFF_FFF1);
    check("arith.exit_cycle", cyc, 8);
    check("arith.instr_const", instr1, 4);
    check("arith.arith_const", arith1, 3);
    check("arith.ctrl_const", ctrl1, 1);

    // Logic ops with sign-extended immediates
    prog = {enc_i(7, 0, 1, 'h0F0F), enc_i(9, 1, 2, 'h00FF), enc_r(10, 1, 2, 3), enc_i(17, 0, 0, 0)};
    load_prog(); model_run(); run_dut(200, 0, cyc, pc_at);
    compare_all("logic", cyc);
    read_reg(2, v); check("logic.r2_const", v, 32'h0000_000F);
    read_reg(3, v); check("logic.r3_const", v, 32'h0000_0F00);
    check("logic.count_const", logic1, 3);

    // Store then load through R0+0x100
    load_word(32'h100, 32'd0);
    prog = {enc_i(1, 0, 1, 'h05A5), enc_i(13, 0, 1, 'h100), enc_i(12, 0, 4, 'h100), enc_i(17, 0, 0, 0)};
    load_prog(); model_run();
    we_before = we_total;
    run_dut(200, 0, cyc, pc_at);
    compare_all("ldst", cyc);
    check("ldst.we_cycles", we_total - we_before, 1);
    check("ldst.we_addr", we_last_addr, 32'h100);
    read_reg(4, v); check("ldst.r4_const", v, 32'h0000_05A5);
    check("ldst.mem_word", rd_mem1(32'h100), 32'h0000_05A5);
    check("ldst.mem_count_const", memc1, 2);

    // BZ taken and not taken from pc 0x10
    for (int t = 0; t < 2; t++) begin
      prog = {enc_i(1, 0, 5, t * 3), enc_i(1, 0, 8, 1), enc_i(1, 8, 8, 1), enc_i(1, 8, 8, 1),
              enc_i(14, 5, 0, 2), enc_i(1, 0, 7, 9), enc_i(17, 0, 0, 0)};
      load_prog(); model_run(); run_dut(200, 10, cyc, pc_at);
      compare_all($sformatf("bz%0d", t), cyc);
      check($sformatf("bz%0d.next_pc", t), pc_at, (t == 0) ? 32'h18 : 32'h14);
      check($sformatf("bz%0d.taken_const", t), taken1, (t == 0) ? 32'd1 : 32'd0);
    end

    // JR to 0x40
    prog = {enc_i(1, 0, 6, 'h40), enc_r(16, 6, 0, 0)};
    while (prog.size() < 16) prog.push_back(enc_i(1, 0, 9, 1));
    prog.push_back(enc_i(17, 0, 0, 0));
    load_prog(); model_run(); run_dut(200, 4, cyc, pc_at);
    compare_all("jr", cyc);
    check("jr.next_pc", pc_at, 32'h40);
    check("jr.taken_const", taken1, 1);

    // BEQ with offset -1 loops back once
    prog = {enc_i(1, 0, 3, 1), enc_i(11, 3, 3, 1), enc_i(15, 3, 0, -1), enc_i(17, 0, 0, 0)};
    load_prog(); model_run(); run_dut(200, 6, cyc, pc_at);
    compare_all("beq", cyc);
    check("beq.loop_pc", pc_at, 32'h4);
    check("beq.instr_const", instr1, 6);

    // Reset while a store sits in MEM
    load_word(32'h100, 32'd0);
    prog = {enc_i(1, 0, 1, 'h77), enc_i(13, 0, 1, 'h100), enc_i(17, 0, 0, 0)};
    load_prog();
    we_before = we_total;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rstmem.we_in_mem", 32'(mem_we1), 32'd1);
    rst_n = 1'b0; #1;
    check("rstmem.we_gated", 32'(mem_we1), 32'd0);
    @(posedge clk); #1;
    check("rstmem.no_write", we_total - we_before, 0);
    check("rstmem.mem_word", rd_mem1(32'h100), 32'd0);
    check("rstmem.pc", pc1, 32'd0);
    check("rstmem.exit", 32'(exit1), 32'd0);
    check("rstmem.instr", instr1, 32'd0);
    check("rstmem.arith", arith1, 32'd0);
    read_reg(1, v); check("rstmem.r1", v, 32'd0);
    @(negedge clk);

    // Random programs: R31 is a data-region base that random ops never write
    for (int p = 0; p < 6; p++) begin
      for (int w = 0; w < 64; w++) load_word(32'h400 + 32'(w * 4), $urandom);
      prog = {enc_i(1, 0, 31, 'h400)};
      for (int k = 0; k < 24; k++) begin
        sel = int'($urandom_range(0, 11));
        if (sel <= 5) begin
          if ($urandom_range(0, 1) == 1)
            prog.push_back(enc_i(int'($urandom_range(0, 5)) * 2 + 1, int'($urandom_range(0, 7)),
                                 int'($urandom_range(0, 7)), int'($urandom)));
          else
            prog.push_back(enc_r(int'($urandom_range(0, 5)) * 2, int'($urandom_range(0, 7)),
                                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
        end else if (sel <= 7)
          prog.push_back(enc_i(12 + sel - 6, 31, int'($urandom_range(0, 7)), int'($urandom_range(0, 63)) * 4));
        else if (sel <= 9)
          prog.push_back(enc_i(14 + sel - 8, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                               int'($urandom_range(1, 3))));
        else
          prog.push_back({6'(int'($urandom_range(18, 63))), 26'($urandom)});
      end
      repeat (4) prog.push_back(enc_i(17, 0, 0, 0));
      load_prog(); model_run(); run_dut(500, 0, cyc, pc_at);
      compare_all($sformatf("rand%0d", p), cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
